asm_ctrl: RTL and testbench

- Layer sequencer for the ASM binary-network compute block.
- Accepts a start pulse plus per-layer lengths and streams pixel/weight/BN beats from an upstream valid/ready source into ASM (asm_reception phase).
- Then holds calculate_en for a programmed cycle count, drives asm_send, deserialises ASM's 1-bit data_out into a RESULT_WIDTH word, and signals done.
- Sits between the layer scheduler/host and one ASM instance.

---
 rtl/asm_pkg.sv | 24 ++
 rtl/asm_ctrl_if.sv | 43 ++++
 rtl/asm_result_deser.sv | 54 +++++
 rtl/asm_ctrl.sv | 153 +++++++++++++++
 tb/tb_asm_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/asm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : asm_pkg
// Purpose  : Shared state encoding and default widths for the ASM controller,
//            the ASM core and their benches.
// Revision : 1.0 - initial release
// ============================================================================
package asm_pkg;

    localparam int DEF_IMG_WIDTH    = 16;
    localparam int DEF_BN_WIDTH     = 16;
    localparam int DEF_RESULT_WIDTH = 6;
    localparam int DEF_CNT_WIDTH    = 10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_CALC = 3'd2;
    localparam state_t ST_SEND = 3'd3;
    localparam state_t ST_DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/asm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : asm_src_if / asm_core_if
// Purpose  : Upstream beat stream (source -> controller) and the controller's
//            drive bundle toward one ASM instance.
// Revision : 1.0 - initial release
// ============================================================================
interface asm_src_if
    import asm_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int BN_WIDTH  = DEF_BN_WIDTH
);
    logic                 src_valid;
    logic                 src_ready;
    logic [IMG_WIDTH-1:0] src_pix;
    logic                 src_weight;
    logic [BN_WIDTH-1:0]  src_bn;

    modport master (output src_valid, src_pix, src_weight, src_bn, input  src_ready);
    modport slave  (input  src_valid, src_pix, src_weight, src_bn, output src_ready);
endinterface

interface asm_core_if
    import asm_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int BN_WIDTH  = DEF_BN_WIDTH
);
    logic                 asm_reception;
    logic                 calculate_en;
    logic                 asm_send;
    logic                 data_weights;
    logic [IMG_WIDTH-1:0] data_pix;
    logic [BN_WIDTH-1:0]  data_bn;
    logic                 data_out;

    modport master (output asm_reception, calculate_en, asm_send, data_weights, data_pix, data_bn,
                    input  data_out);
    modport slave  (input  asm_reception, calculate_en, asm_send, data_weights, data_pix, data_bn,
                    output data_out);
endinterface
`default_nettype wire

// File: rtl/asm_result_deser.sv
`default_nettype none
// ============================================================================
// Module   : asm_result_deser
// Purpose  : Collects ASM's serial result bits LSB-first into a parallel word.
// Revision : 1.0 - initial release
// ============================================================================
module asm_result_deser
    import asm_pkg::*;
#(
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic                    data_out,
    output logic                    last,
    output logic [RESULT_WIDTH-1:0] result,
    output logic                    result_valid
);

    localparam int                   BIT_CNT_W = $clog2(RESULT_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(RESULT_WIDTH - 1);

    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    logic [RESULT_WIDTH-1:0] r_shift;
    logic [RESULT_WIDTH-1:0] w_shift_next;

    // New bits enter at the top so the first sample ends up in bit 0.
    assign w_shift_next = {data_out, r_shift[RESULT_WIDTH-1:1]};
    assign last         = sample_en && (r_bit_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (sample_en) begin
                r_shift <= w_shift_next;
                if (last) begin
                    r_bit_cnt    <= '0;
                    result       <= w_shift_next;
                    result_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/asm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : asm_ctrl
// Purpose  : Layer sequencer for one ASM instance: load beats, compute, shift
//            the result out and report completion.
// Revision : 1.0 - initial release
// ============================================================================
module asm_ctrl
    import asm_pkg::*;
#(
    parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int BN_WIDTH     = DEF_BN_WIDTH,
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    cfg_load_len,
    input  logic [CNT_WIDTH-1:0]    cfg_calc_len,
    asm_src_if.slave                src,
    asm_core_if.master              core,
    output logic [RESULT_WIDTH-1:0] result,
    output logic                    result_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int                    SEND_CNT_W = $clog2(RESULT_WIDTH + 1);
    localparam logic [SEND_CNT_W-1:0] SEND_BEATS = SEND_CNT_W'(RESULT_WIDTH);

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_WIDTH-1:0]  r_load_len;
    logic [CNT_WIDTH-1:0]  r_calc_len;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_calc_cnt;
    logic [SEND_CNT_W-1:0] r_send_cnt;
    logic                  r_reception;
    logic                  r_send_d;
    logic [IMG_WIDTH-1:0]  r_pix;
    logic                  r_weight;
    logic [BN_WIDTH-1:0]   r_bn;

    logic w_launch;
    logic w_accept;
    logic w_last_beat;
    logic w_calc_en;
    logic w_last_calc;
    logic w_send;
    logic w_last_sample;

    assign w_launch    = (r_state == ST_IDLE) && start;
    assign w_accept    = (r_state == ST_LOAD) && src.src_valid;
    assign w_last_beat = w_accept && (r_beat_cnt == r_load_len - CNT_WIDTH'(1));

    // The final load beat reaches ASM one cycle late; compute and send hold
    // off while it is still on the wire so the three strobes never overlap.
    assign w_calc_en   = (r_state == ST_CALC) && !r_reception;
    assign w_last_calc = w_calc_en && (r_calc_cnt == r_calc_len - CNT_WIDTH'(1));
    assign w_send      = (r_state == ST_SEND) && !r_reception && (r_send_cnt != SEND_BEATS);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_load_len != '0)      w_state_next = ST_LOAD;
                    else if (cfg_calc_len != '0) w_state_next = ST_CALC;
                    else                         w_state_next = ST_SEND;
                end
            end
            ST_LOAD: begin
                if (w_last_beat) w_state_next = (r_calc_len != '0) ? ST_CALC : ST_SEND;
            end
            ST_CALC: begin
                if (w_last_calc) w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_last_sample) w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_load_len <= '0;
            r_calc_len <= '0;
            r_beat_cnt <= '0;
            r_calc_cnt <= '0;
            r_send_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_launch) begin
                r_load_len <= cfg_load_len;
                r_calc_len <= cfg_calc_len;
                r_beat_cnt <= '0;
                r_calc_cnt <= '0;
                r_send_cnt <= '0;
            end else begin
                if (w_accept)  r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
                if (w_calc_en) r_calc_cnt <= r_calc_cnt + CNT_WIDTH'(1);
                if (w_send)    r_send_cnt <= r_send_cnt + SEND_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reception <= 1'b0;
            r_send_d    <= 1'b0;
            r_pix       <= '0;
            r_weight    <= 1'b0;
            r_bn        <= '0;
        end else begin
            r_reception <= w_accept;
            r_send_d    <= w_send;
            if (w_accept) begin
                r_pix    <= src.src_pix;
                r_weight <= src.src_weight;
                r_bn     <= src.src_bn;
            end
        end
    end

    // ASM answers each send request one cycle later.
    asm_result_deser #(
        .RESULT_WIDTH (RESULT_WIDTH)
    ) u_deser (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (r_send_d),
        .data_out     (core.data_out),
        .last         (w_last_sample),
        .result       (result),
        .result_valid (result_valid)
    );

    assign src.src_ready      = (r_state == ST_LOAD);
    assign core.asm_reception = r_reception;
    assign core.calculate_en  = w_calc_en;
    assign core.asm_send      = w_send;
    assign core.data_weights  = r_weight;
    assign core.data_pix      = r_pix;
    assign core.data_bn       = r_bn;
    assign busy               = (r_state != ST_IDLE);
    assign done               = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_asm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_asm_ctrl
// Purpose  : Scoreboard bench for asm_ctrl with a behavioural ASM responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asm_ctrl;
    import asm_pkg::*;

    localparam int IW = DEF_IMG_WIDTH;
    localparam int BW = DEF_BN_WIDTH;
    localparam int RW = DEF_RESULT_WIDTH;
    localparam int CW = DEF_CNT_WIDTH;

    typedef struct packed {
        logic [IW-1:0] pix;
        logic          w;
        logic [BW-1:0] bn;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_load_len = '0;
    logic [CW-1:0] cfg_calc_len = '0;
    logic [RW-1:0] result;
    logic          result_valid;
    logic          busy;
    logic          done;

    asm_src_if  #(.IMG_WIDTH(IW), .BN_WIDTH(BW)) src ();
    asm_core_if #(.IMG_WIDTH(IW), .BN_WIDTH(BW)) core ();

    asm_ctrl #(
        .IMG_WIDTH(IW), .BN_WIDTH(BW), .RESULT_WIDTH(RW), .CNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_load_len (cfg_load_len),
        .cfg_calc_len (cfg_calc_len),
        .src          (src.slave),
        .core         (core.master),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_recv, n_calc, n_send, n_done, n_rv, cur_load, start_cyc, done_cyc;
    bit calc_seen;
    bit acc_prev = 1'b0;
    beat_t         exp_beats[$];
    logic [RW-1:0] exp_res[$];
    logic [RW-1:0] asm_bits = '0;
    int            asm_idx  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural ASM: one serial bit per send request, one cycle later.
    initial begin
        core.data_out = 1'b0;
        forever begin
            @(negedge clk);
            if (core.asm_send === 1'b1) begin
                @(posedge clk);
                #1;
                core.data_out = asm_bits[asm_idx];
                asm_idx = (asm_idx + 1) % RW;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (core.asm_reception) begin
                n_recv++;
                check("recv_one_cycle_after_accept", 32'(acc_prev), 32'd1);
                if (exp_beats.size() == 0) begin
                    check("recv_unexpected", 32'd1, 32'd0);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("data_pix", 32'(core.data_pix), 32'(b.pix));
                    check("data_weights", 32'(core.data_weights), 32'(b.w));
                    check("data_bn", 32'(core.data_bn), 32'(b.bn));
                end
            end
            if (core.calculate_en) begin
                if (!calc_seen) begin
                    calc_seen = 1'b1;
                    check("calc_after_all_beats", 32'(n_recv), 32'(cur_load));
                end
                n_calc++;
            end
            if (core.asm_send) n_send++;
            if (core.asm_reception || core.calculate_en || core.asm_send)
                check("strobe_onehot",
                      32'(core.asm_reception) + 32'(core.calculate_en) + 32'(core.asm_send), 32'd1);
            if (result_valid) begin
                n_rv++;
                if (exp_res.size() == 0) check("result_unexpected", 32'd1, 32'd0);
                else check("result", 32'(result), 32'(exp_res.pop_front()));
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        acc_prev = src.src_valid && src.src_ready;
    end

    task automatic drive_src(input int n, input logic [IW-1:0] pix0,
                             input logic [15:0] wmask, input logic [5:0] pat);
        int k = 0;
        int c = 0;
        while (k < n && c < 500) begin
            src.src_valid  = pat[c % 6];
            src.src_pix    = pix0 + IW'(k);
            src.src_weight = wmask[k];
            src.src_bn     = 16'hB000 + BW'(k);
            @(negedge clk);
            if (src.src_valid && src.src_ready) begin
                exp_beats.push_back('{pix: src.src_pix, w: src.src_weight, bn: src.src_bn});
                k++;
            end
            @(posedge clk);
            #1;
            c++;
        end
        src.src_valid = 1'b0;
        if (k < n) check("src_beats_timeout", 32'(k), 32'(n));
    endtask

    task automatic run_layer(input int load, input int calc, input logic [IW-1:0] pix0,
                             input logic [15:0] wmask, input logic [5:0] pat,
                             input logic [RW-1:0] bits, input logic [RW-1:0] expr,
                             input int exp_lat, input bit restart);
        int guard;
        n_recv = 0; n_calc = 0; n_send = 0; n_done = 0; n_rv = 0;
        calc_seen = 1'b0; cur_load = load; done_cyc = -1;
        asm_bits = bits; asm_idx = 0;
        exp_res.push_back(expr);
        cfg_load_len = CW'(load);
        cfg_calc_len = CW'(calc);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_load_len = '1;
        cfg_calc_len = '1;
        check("busy_after_start", 32'(busy), 32'd1);
        if (load > 0) drive_src(load, pix0, wmask, pat);
        if (restart) begin
            guard = 0;
            while (n_calc < 2 && guard < 200) begin
                @(posedge clk);
                #1;
                guard++;
            end
            cfg_load_len = CW'(9);
            cfg_calc_len = CW'(9);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        guard = 0;
        while (n_done == 0 && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("layer_done_seen", 32'(n_done != 0), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_pulse_width", 32'(done), 32'd0);
        check("recv_count", 32'(n_recv), 32'(load));
        check("calc_count", 32'(n_calc), 32'(calc));
        check("send_count", 32'(n_send), 32'(RW));
        check("done_count", 32'(n_done), 32'd1);
        check("result_valid_count", 32'(n_rv), 32'd1);
        check("result_held", 32'(result), 32'(expr));
        check("beats_drained", 32'(exp_beats.size()), 32'd0);
        if (exp_lat >= 0) check("done_latency", 32'(done_cyc - start_cyc), 32'(exp_lat));
    endtask

    initial begin
        src.src_valid  = 1'b0;
        src.src_pix    = '0;
        src.src_weight = 1'b0;
        src.src_bn     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_src_ready", 32'(src.src_ready), 32'd0);
        check("rst_strobes", {29'd0, core.asm_reception, core.calculate_en, core.asm_send}, 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Nominal layer: result bits 1,0,1,0,0,1 LSB first -> 0x25.
        run_layer(4, 5, 16'h0011, 16'b1101, 6'b111111, 6'b100101, 6'h25, 18, 1'b0);

        // Reset after 3 of 8 beats.
        cfg_load_len = CW'(8);
        cfg_calc_len = CW'(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drive_src(3, 16'h0200, 16'h00ff, 6'b111111);
        check("recv_before_reset", 32'(core.asm_reception), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_src_ready", 32'(src.src_ready), 32'd0);
        check("midrst_strobes", {29'd0, core.asm_reception, core.calculate_en, core.asm_send}, 32'd0);
        check("midrst_data_pix", 32'(core.data_pix), 32'd0);
        check("midrst_data_bn", 32'(core.data_bn), 32'd0);
        check("midrst_data_weights", 32'(core.data_weights), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        @(posedge clk);
        #1;
        exp_beats.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fresh layer after reset starts again from beat 0.
        run_layer(4, 5, 16'h0100, 16'b0110, 6'b111111, 6'b011010, 6'h1A, 18, 1'b0);

        // Backpressure: valid pattern 1,0,0,1,0,1.
        run_layer(3, 2, 16'h0A00, 16'b101, 6'b101001, 6'b111000, 6'h38, -1, 1'b0);

        // Zero lengths go straight to SEND; done RW+2 cycles after start.
        run_layer(0, 0, 16'h0000, 16'h0, 6'b111111, 6'b000111, 6'h07, RW + 2, 1'b0);

        // Second start during CALC with different cfg must be ignored.
        run_layer(2, 4, 16'h0C00, 16'b01, 6'b111111, 6'b010101, 6'h15, -1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("idle_after_ignored_start", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
